// File: rtl/program_loader_pkg.sv
// Shared constants for the operator-loaded program store
// and the control encodings it must agree with.
package program_loader_pkg;

  typedef enum logic [1:0] {
    MODE_LOAD = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_HALT = 2'b10
  } mode_e;

  // Jump with offset -1: the core spins on itself.
  localparam logic [7:0] HALT_INSTR_DEF = 8'hFF;

  localparam logic [1:0] OP_ALU = 2'b00;
  localparam logic [1:0] OP_LD  = 2'b01;
  localparam logic [1:0] OP_ST  = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  localparam int unsigned MEM_DEPTH = 256;

  function automatic logic pc_valid(
    input logic [7:0] pc,
    input logic [8:0] cnt
  );
    return {1'b0, pc} < cnt;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push button to a one-cycle rising-edge pulse:
// 2-FF synchronizer, stability counter, edge detect.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic          r_level_q;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_s1      <= i_btn;
      r_s2      <= r_s1;
      r_level_q <= r_level;
      // Any sample agreeing with the accepted level restarts the count.
      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_level <= r_s2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_pulse = r_level & ~r_level_q;

endmodule

// File: rtl/program_loader.sv
// Operator-filled 256x8 program store feeding the core,
// with load/run/halt sequencing and core clock-enable.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 16,
  parameter logic [7:0] HALT_INSTR      = HALT_INSTR_DEF
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [7:0] sw_data,
  input  logic       load_btn,
  input  logic       run_btn,
  input  logic [7:0] pc,
  output logic [7:0] instruction,
  output logic       cpu_en,
  output logic       cpu_restart,
  output logic [1:0] mode,
  output logic [8:0] load_count,
  output logic       full
);

  mode_e      r_mode;
  mode_e      w_mode_nxt;
  logic [8:0] r_count;
  logic [8:0] w_count_nxt;
  logic       r_cpu_en;
  logic       r_restart;
  logic       w_restart;
  logic       w_we;
  logic       w_ld_p;
  logic       w_run_p;
  logic       w_full;
  logic       w_active;
  logic [7:0] r_mem [MEM_DEPTH];

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ld_db (
    .clk    (CLK),
    .rst_n  (Reset),
    .i_btn  (load_btn),
    .o_pulse(w_ld_p)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_run_db (
    .clk    (CLK),
    .rst_n  (Reset),
    .i_btn  (run_btn),
    .o_pulse(w_run_p)
  );

  assign w_full   = (r_count == 9'd256);
  assign w_active = (r_mode == MODE_RUN) ||
                    (r_mode == MODE_HALT);

  // Stale bytes past load_count stay hidden behind the compare.
  assign instruction =
    (w_active && pc_valid(pc, r_count)) ?
    r_mem[pc] : HALT_INSTR;

  always_comb begin
    w_mode_nxt  = r_mode;
    w_count_nxt = r_count;
    w_restart   = 1'b0;
    w_we        = 1'b0;
    case (r_mode)
      MODE_LOAD: begin
        if (w_ld_p) begin
          if (!w_full) begin
            w_we        = 1'b1;
            w_count_nxt = r_count + 9'd1;
          end
        end else if (w_run_p && r_count != 9'd0) begin
          w_mode_nxt = MODE_RUN;
          w_restart  = 1'b1;
        end
      end
      MODE_RUN: begin
        if (w_ld_p) begin
          w_mode_nxt  = MODE_LOAD;
          w_count_nxt = 9'd0;
        end else if (w_run_p) begin
          w_restart = 1'b1;
        end else if (instruction == HALT_INSTR) begin
          w_mode_nxt = MODE_HALT;
        end
      end
      MODE_HALT: begin
        if (w_ld_p) begin
          w_mode_nxt  = MODE_LOAD;
          w_count_nxt = 9'd0;
        end else if (w_run_p) begin
          w_mode_nxt = MODE_RUN;
          w_restart  = 1'b1;
        end
      end
      default: begin
        w_mode_nxt = MODE_LOAD;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_mode    <= MODE_LOAD;
      r_count   <= 9'd0;
      r_cpu_en  <= 1'b0;
      r_restart <= 1'b0;
    end else begin
      r_mode    <= w_mode_nxt;
      r_count   <= w_count_nxt;
      r_cpu_en  <= (w_mode_nxt == MODE_RUN);
      r_restart <= w_restart;
    end
  end

  // Contents survive reset; load_count alone decides visibility.
  always_ff @(posedge CLK) begin
    if (w_we) begin
      r_mem[r_count[7:0]] <= sw_data;
    end
  end

  assign cpu_en      = r_cpu_en;
  assign cpu_restart = r_restart;
  assign mode        = r_mode;
  assign load_count  = r_count;
  assign full        = w_full;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed table,
// hand-timed corner cases and a randomized model comparison.
module tb_program_loader;

  localparam int DB   = 16;
  localparam int HOLD = DB + 6;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [7:0] sw_data;
  logic       load_btn;
  logic       run_btn;
  logic [7:0] pc;
  logic [7:0] instruction;
  logic       cpu_en;
  logic       cpu_restart;
  logic [1:0] mode;
  logic [8:0] load_count;
  logic       full;

  always #5 CLK = ~CLK;

  program_loader #(
    .DEBOUNCE_CYCLES(DB),
    .HALT_INSTR     (8'hFF)
  ) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .sw_data    (sw_data),
    .load_btn   (load_btn),
    .run_btn    (run_btn),
    .pc         (pc),
    .instruction(instruction),
    .cpu_en     (cpu_en),
    .cpu_restart(cpu_restart),
    .mode       (mode),
    .load_count (load_count),
    .full       (full)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural model: 0=load 1=run 2=halt
  logic [7:0] m_mem [256];
  int         m_cnt;
  int         m_mode;

  typedef struct {
    int         op;
    logic [7:0] d;
    logic [7:0] p;
    int         e_mode;
    int         e_cnt;
    logic [7:0] e_ins;
    int         e_en;
    int         e_rst;
  } vec_t;

  vec_t tv [12];

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int m_instr();
    if (m_mode != 0 && int'(pc) < m_cnt) return int'(m_mem[pc]);
    return 255;
  endfunction

  function automatic void m_settle();
    if (m_mode == 1 && m_instr() == 255) m_mode = 2;
  endfunction

  function automatic int m_apply(input bit ld, input bit rn,
                                 input logic [7:0] d);
    int r;
    r = 0;
    if (m_mode == 0) begin
      if (ld) begin
        if (m_cnt < 256) begin
          m_mem[m_cnt] = d;
          m_cnt++;
        end
      end else if (rn && m_cnt > 0) begin
        m_mode = 1;
        r = 1;
      end
    end else if (ld) begin
      m_mode = 0;
      m_cnt = 0;
    end else if (rn) begin
      m_mode = 1;
      r = 1;
    end
    m_settle();
    return r;
  endfunction

  task automatic check_all(input string nm);
    chk({nm, ".mode"}, int'(mode), m_mode);
    chk({nm, ".cnt"}, int'(load_count), m_cnt);
    chk({nm, ".full"}, int'(full), int'(m_cnt == 256));
    chk({nm, ".en"}, int'(cpu_en), int'(m_mode == 1));
    chk({nm, ".ins"}, int'(instruction), m_instr());
  endtask

  task automatic press(input bit ld, input bit rn,
                       input logic [7:0] d,
                       output int nrst, output int bad);
    nrst = 0;
    bad = 0;
    sw_data = d;
    load_btn = ld;
    run_btn = rn;
    for (int i = 0; i < 2 * HOLD; i++) begin
      if (i == HOLD) begin
        load_btn = 1'b0;
        run_btn = 1'b0;
      end
      tick();
      if (cpu_restart) begin
        nrst++;
        if (mode != 2'b01 || !cpu_en) bad++;
      end
    end
  endtask

  task automatic do_op(input bit ld, input bit rn,
                       input logic [7:0] d,
                       input string nm);
    int nr, bad, er;
    press(ld, rn, d, nr, bad);
    er = m_apply(ld, rn, d);
    chk({nm, ".rst"}, nr, er);
    chk({nm, ".rst_tm"}, bad, 0);
    check_all(nm);
  endtask

  task automatic set_pc(input logic [7:0] p,
                        input string nm);
    pc = p;
    tick();
    tick();
    m_settle();
    check_all(nm);
  endtask

  initial begin
    int nr, bad, er;
    Reset = 1'b0;
    sw_data = 8'h00;
    load_btn = 1'b0;
    run_btn = 1'b0;
    pc = 8'h00;
    m_cnt = 0;
    m_mode = 0;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;

    repeat (3) tick();
    Reset = 1'b1;
    tick();
    chk("rst.mode", int'(mode), 0);
    chk("rst.cnt", int'(load_count), 0);
    chk("rst.full", int'(full), 0);
    chk("rst.en", int'(cpu_en), 0);
    chk("rst.restart", int'(cpu_restart), 0);
    for (int i = 0; i < 4; i++) begin
      pc = 8'(i * 85);
      #1;
      chk("rst.ins", int'(instruction), 8'hFF);
    end

    // op: 0=pc only 1=load 2=run 3=both
    tv[0]  = '{2, 8'h00, 8'h00, 0, 0, 8'hFF, 0, 0};
    tv[1]  = '{1, 8'h41, 8'h00, 0, 1, 8'hFF, 0, 0};
    tv[2]  = '{1, 8'h86, 8'h00, 0, 2, 8'hFF, 0, 0};
    tv[3]  = '{1, 8'hFF, 8'h00, 0, 3, 8'hFF, 0, 0};
    tv[4]  = '{2, 8'h00, 8'h00, 1, 3, 8'h41, 1, 1};
    tv[5]  = '{0, 8'h00, 8'h01, 1, 3, 8'h86, 1, 0};
    tv[6]  = '{0, 8'h00, 8'h02, 2, 3, 8'hFF, 0, 0};
    tv[7]  = '{0, 8'h00, 8'h03, 2, 3, 8'hFF, 0, 0};
    tv[8]  = '{0, 8'h00, 8'h00, 2, 3, 8'h41, 0, 0};
    tv[9]  = '{2, 8'h00, 8'h00, 1, 3, 8'h41, 1, 1};
    tv[10] = '{1, 8'h55, 8'h00, 0, 0, 8'hFF, 0, 0};
    tv[11] = '{2, 8'h00, 8'h00, 0, 0, 8'hFF, 0, 0};

    for (int i = 0; i < 12; i++) begin
      string nm;
      nm = $sformatf("tv%0d", i);
      pc = tv[i].p;
      if (tv[i].op == 0) begin
        tick();
        tick();
        m_settle();
      end else begin
        press(tv[i].op[0], tv[i].op[1], tv[i].d, nr, bad);
        er = m_apply(tv[i].op[0], tv[i].op[1], tv[i].d);
        chk({nm, ".rst"}, nr, tv[i].e_rst);
        chk({nm, ".rst_tm"}, bad, 0);
      end
      chk({nm, ".mode"}, int'(mode), tv[i].e_mode);
      chk({nm, ".cnt"}, int'(load_count), tv[i].e_cnt);
      chk({nm, ".ins"}, int'(instruction), int'(tv[i].e_ins));
      chk({nm, ".en"}, int'(cpu_en), tv[i].e_en);
    end

    // Halt lands exactly one edge after the jump-to-self is seen.
    do_op(1, 0, 8'h41, "h.ld0");
    do_op(1, 0, 8'h86, "h.ld1");
    do_op(1, 0, 8'hFF, "h.ld2");
    pc = 8'h00;
    do_op(0, 1, 8'h00, "h.run");
    pc = 8'h02;
    #1;
    chk("halt.pre_ins", int'(instruction), 8'hFF);
    chk("halt.pre_en", int'(cpu_en), 1);
    chk("halt.pre_mode", int'(mode), 1);
    tick();
    chk("halt.mode", int'(mode), 2);
    chk("halt.en", int'(cpu_en), 0);
    m_settle();

    // Bounce rejection: 3-cycle toggles never reach DB samples.
    do_op(1, 0, 8'h00, "b.abort");
    sw_data = 8'h77;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) load_btn = ~load_btn;
      tick();
    end
    load_btn = 1'b0;
    repeat (HOLD) tick();
    chk("bounce.cnt", int'(load_count), 0);
    do_op(1, 0, 8'h12, "b.clean");
    chk("bounce.clean_cnt", int'(load_count), 1);

    // Simultaneous pulses in LOAD and in HALT.
    do_op(1, 1, 8'h33, "s.load");
    chk("both_load.mode", int'(mode), 0);
    chk("both_load.cnt", int'(load_count), 2);
    pc = 8'h05;
    do_op(0, 1, 8'h00, "s.run");
    chk("both.pre_halt", int'(mode), 2);
    do_op(1, 1, 8'h44, "s.halt");
    chk("both_halt.mode", int'(mode), 0);
    chk("both_halt.cnt", int'(load_count), 0);

    // Fill the store; the 257th press is dropped.
    for (int i = 0; i < 257; i++) begin
      do_op(1, 0, 8'(i) ^ 8'h5A, $sformatf("f%0d", i));
    end
    chk("full.cnt", int'(load_count), 256);
    chk("full.flag", int'(full), 1);
    pc = 8'hFF;
    do_op(0, 1, 8'h00, "f.run");
    chk("full.last", int'(instruction), 8'hA5);
    chk("full.mode", int'(mode), 1);

    // Asynchronous reset in the middle of a run.
    #3;
    Reset = 1'b0;
    #1;
    chk("mrst.en", int'(cpu_en), 0);
    chk("mrst.mode", int'(mode), 0);
    chk("mrst.cnt", int'(load_count), 0);
    chk("mrst.ins", int'(instruction), 8'hFF);
    chk("mrst.restart", int'(cpu_restart), 0);
    m_mode = 0;
    m_cnt = 0;
    tick();
    Reset = 1'b1;
    tick();
    check_all("mrst.after");

    // Randomized operations against the model.
    for (int i = 0; i < 80; i++) begin
      int r;
      logic [7:0] d;
      string nm;
      nm = $sformatf("r%0d", i);
      r = int'($urandom_range(0, 9));
      d = 8'($urandom);
      if (r < 5) do_op(1, 0, d, nm);
      else if (r < 7) do_op(0, 1, d, nm);
      else if (r < 8) do_op(1, 1, d, nm);
      else set_pc(8'($urandom_range(0, 12)), nm);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Upstream instruction source for the 8-bit single-cycle core. Holds a 256 x 8 program store that the operator fills one byte at a time from the slide switches and a load button. It then serves `instruction` combinationally for the core's `pc`, gating the core with `cpu_en` and detecting the halt idiom. It replaces the fixed instruction ROM on the board build.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized samples required before a button level is accepted.
- `HALT_INSTR`, default 8'hFF: jump with offset -1, i.e. jump-to-self. Returned for every unloaded address and used for halt detection.

Ports:
- `CLK` in 1: single clock, rising edge.
- `Reset` in 1: asynchronous, active-low reset (asserted at 0).
- `sw_data` in 8: instruction byte to be loaded.
- `load_btn` in 1: raw, asynchronous push button that writes `sw_data`.
- `run_btn` in 1: raw, asynchronous push button that starts or restarts execution.
- `pc` in 8: program counter from the core.
- `instruction` out 8: combinational read of the program store at `pc`.
- `cpu_en` out 1: registered clock-enable to the core's PC, register file and data memory.
- `cpu_restart` out 1: registered one-cycle pulse; the core clears its PC to 0 on it.
- `mode` out 2: current FSM state.
- `load_count` out 9: number of bytes loaded, range 0..256.
- `full` out 1: high when `load_count` == 256.

## Operation
- **Buttons.** Each button passes through a 2-FF synchronizer and then a debouncer. The debounced level changes only after `DEBOUNCE_CYCLES` equal samples. A 0->1 edge of the debounced level produces a one-cycle pulse: `ld_p` for load, `run_p` for run.
- **FSM states:** LOAD=2'b00, RUN=2'b01, HALT=2'b10. There is no 2'b11 state; if reached, the FSM goes to LOAD.
- **LOAD state:**
  - `ld_p` with !`full`: mem[`load_count[7:0]`] <= `sw_data`; `load_count`++.
  - `ld_p` with `full`: ignored; no write, no count change.
  - `run_p` with `load_count` > 0: go to RUN and assert `cpu_restart` for 1 cycle.
  - `run_p` with `load_count` == 0: ignored.
  - `ld_p` and `run_p` in the same cycle: the load is performed and the run is ignored.
- **RUN state:**
  - `cpu_en`=1.
  - If `instruction` == `HALT_INSTR`: go to HALT; `cpu_en` drops next cycle.
  - `ld_p` in RUN: abort to LOAD with `load_count` cleared to 0 and no write.
  - `run_p` in RUN: restart pulse only; the state is unchanged.
- **HALT state:**
  - `run_p`: go to RUN with a `cpu_restart` pulse.
  - `ld_p`: go to LOAD with `load_count` cleared; the pressed byte is not written.
  - Both pulses in the same cycle: `ld_p` wins.
- **Read path:**
  - `instruction` = (`mode`==RUN || `mode`==HALT) && `pc` < `load_count` ? mem[`pc`] : `HALT_INSTR`.
  - In LOAD, `instruction` is always `HALT_INSTR`.
  - The comparison is 9-bit: when `load_count`=256, every `pc` is valid.
- **Memory.** Memory contents are not cleared by reset or by a return to LOAD. Stale bytes are masked by the `load_count` compare.

## Timing
- **Reset values:**
  - `mode`=LOAD, `load_count`=0, `full`=0, `cpu_en`=0, `cpu_restart`=0.
  - `instruction`=`HALT_INSTR`.
  - Synchronizers and debouncers reset to 0 (released).
- **Button latency:** 2 (sync) + `DEBOUNCE_CYCLES` + 1 (edge) cycles from a stable press to the pulse.
- **Write latency:** the write and the `load_count` increment land on the edge after `ld_p`. The written byte is readable via `pc` once in RUN.
- **`run_p` at edge N:**
  - At N+1: `mode`=RUN, `cpu_restart`=1, `cpu_en`=1.
  - At N+2: `cpu_restart`=0.
  - The core sees its PC cleared on the first enabled edge.
- **Halt:**
  - Detected at an edge where `mode`=RUN and `instruction`==`HALT_INSTR`.
  - `mode`=HALT and `cpu_en`=0 from the next edge. The core therefore executes the halt jump once, which is harmless because it jumps to self.
- **Async `Reset` mid-load or mid-run:** all state returns immediately to the reset values. Subsequent reads give `HALT_INSTR` until reloaded.

## Structure
- **Shared package:** mode encoding (LOAD/RUN/HALT), the `HALT_INSTR` default, and the 2-bit opcode constants shared with the control unit.
- **Sub-module:** `btn_debounce`, parameterized by `DEBOUNCE_CYCLES`, instantiated twice. It contains the synchronizer, the stability counter, and the rising-edge pulse output.
- The program store is a local 256 x 8 register array: synchronous write, asynchronous read.

## Test plan
- **Reset and empty run:** after Reset, press `run_btn` with nothing loaded -> `mode` stays 00, `cpu_en`=0, `instruction`=8'hFF for all `pc`.
- **Load and read back:** load 8'h41, 8'h86, 8'hFF; press run -> `load_count`=3, one `cpu_restart` pulse. With `pc`=0/1/2/3 -> `instruction`=41/86/FF/FF. Halt is taken when `pc`=2 and `cpu_en` falls one cycle later.
- **Bounce rejection:** `load_btn` toggling every 3 cycles for 40 cycles, with `DEBOUNCE_CYCLES`=16 -> no write. A clean hold -> exactly one write.
- **Full store:** 257 load presses -> `load_count`=256, `full`=1, last press ignored. `pc`=8'hFF returns the 256th byte.
- **Simultaneous pulses:** `ld_p` and `run_p` in the same cycle in LOAD -> write performed, `mode` stays LOAD. In HALT -> `mode`=LOAD, `load_count`=0.
- **Mid-run reset:** assert Reset during RUN -> `cpu_en`=0 and `mode`=00 immediately. `instruction` for a previously loaded `pc` reads 8'hFF.
